// File: rtl/operand_fetch.sv
// Operand fetch stage for a dual-issue pipe: register file with bypassed
// writeback, per-pipe skid FIFO absorbing execute stalls, and output registers.
module operand_fetch #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 32,
    parameter int SKID_DEPTH = 2
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  enableA_i,
    input  logic                  pWriteA_i,
    input  logic                  pReadA_i,
    input  logic                  sReadA_i,
    input  logic [1:0]            functionTypeA_i,
    input  logic [6:0]            opcodeA_i,
    input  logic [4:0]            primOperandA_i,
    input  logic [DATA_WIDTH-1:0] secOperandA_i,
    input  logic                  enableB_i,
    input  logic                  pWriteB_i,
    input  logic                  pReadB_i,
    input  logic                  sReadB_i,
    input  logic [1:0]            functionTypeB_i,
    input  logic [6:0]            opcodeB_i,
    input  logic [4:0]            primOperandB_i,
    input  logic [DATA_WIDTH-1:0] secOperandB_i,
    input  logic                  shouldStall_i,
    input  logic                  wbEnableA_i,
    input  logic [4:0]            wbAddrA_i,
    input  logic [DATA_WIDTH-1:0] wbDataA_i,
    input  logic                  wbEnableB_i,
    input  logic [4:0]            wbAddrB_i,
    input  logic [DATA_WIDTH-1:0] wbDataB_i,
    output logic                  isStalled_o,
    output logic                  enableA_o,
    output logic                  pwriteA_o,
    output logic [1:0]            functionTypeA_o,
    output logic [6:0]            opcodeA_o,
    output logic [4:0]            destRegA_o,
    output logic [DATA_WIDTH-1:0] primValueA_o,
    output logic [DATA_WIDTH-1:0] secValueA_o,
    output logic                  enableB_o,
    output logic                  pwriteB_o,
    output logic [1:0]            functionTypeB_o,
    output logic [6:0]            opcodeB_o,
    output logic [4:0]            destRegB_o,
    output logic [DATA_WIDTH-1:0] primValueB_o,
    output logic [DATA_WIDTH-1:0] secValueB_o,
    output logic                  overflow_o
);
    localparam int ADDR_W = 5;
    localparam int OCC_W  = $clog2(SKID_DEPTH + 1);

    typedef struct packed {
        logic                  pwrite;
        logic                  pread;
        logic                  sread;
        logic [1:0]            ftype;
        logic [6:0]            opcode;
        logic [ADDR_W-1:0]     prim;
        logic [DATA_WIDTH-1:0] sec;
    } instr_t;

    logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];
    instr_t                skid_q [2][SKID_DEPTH];
    instr_t                skid_d [2][SKID_DEPTH];
    logic [OCC_W-1:0]      occ_q [2];
    logic [OCC_W-1:0]      occ_d [2];
    logic [OCC_W-1:0]      widx [2];
    instr_t                in_ins [2];
    instr_t                sel [2];
    logic                  in_vld [2];
    logic                  sel_vld [2];
    logic                  has_skid [2];
    logic                  pop [2];
    logic                  push [2];
    logic                  drop [2];
    logic [ADDR_W-1:0]     rd_addr [4];
    logic [DATA_WIDTH-1:0] rd_data [4];
    logic                  stall_d;
    logic                  en_q [2];
    logic                  pw_q [2];
    logic [1:0]            ft_q [2];
    logic [6:0]            op_q [2];
    logic [ADDR_W-1:0]     dst_q [2];
    logic [DATA_WIDTH-1:0] pv_q [2];
    logic [DATA_WIDTH-1:0] sv_q [2];
    logic                  stalled_q;
    logic                  ovf_q;

    always_comb begin
        in_vld[0] = enableA_i;
        in_vld[1] = enableB_i;
        in_ins[0] = {pWriteA_i, pReadA_i, sReadA_i, functionTypeA_i, opcodeA_i,
                     primOperandA_i, secOperandA_i};
        in_ins[1] = {pWriteB_i, pReadB_i, sReadB_i, functionTypeB_i, opcodeB_i,
                     primOperandB_i, secOperandB_i};
        for (int p = 0; p < 2; p++) begin
            has_skid[p] = (occ_q[p] != '0);
            sel[p]      = has_skid[p] ? skid_q[p][0] : in_ins[p];
            sel_vld[p]  = has_skid[p] | in_vld[p];
            pop[p]      = !shouldStall_i && has_skid[p];
            // Input goes to the skid whenever it cannot go straight to the output.
            push[p]     = in_vld[p] && (shouldStall_i || has_skid[p]);
            drop[p]     = push[p] && !pop[p] && (occ_q[p] == OCC_W'(SKID_DEPTH));
            widx[p]     = pop[p] ? occ_q[p] - OCC_W'(1) : occ_q[p];
            skid_d[p]   = skid_q[p];
            if (pop[p]) begin
                for (int i = 0; i < SKID_DEPTH - 1; i++) skid_d[p][i] = skid_q[p][i+1];
            end
            if (push[p] && !drop[p]) begin
                for (int i = 0; i < SKID_DEPTH; i++) begin
                    if (OCC_W'(i) == widx[p]) skid_d[p][i] = in_ins[p];
                end
            end
            occ_d[p] = occ_q[p] + OCC_W'(push[p] && !drop[p]) - OCC_W'(pop[p]);
        end
        stall_d = shouldStall_i | (occ_d[0] != '0) | (occ_d[1] != '0);
    end

    // Operands are read for whichever instruction moves into the output register.
    always_comb begin
        rd_addr[0] = sel[0].prim;
        rd_addr[1] = sel[0].sec[ADDR_W-1:0];
        rd_addr[2] = sel[1].prim;
        rd_addr[3] = sel[1].sec[ADDR_W-1:0];
        for (int r = 0; r < 4; r++) begin
            if (rd_addr[r] == '0)                            rd_data[r] = '0;
            else if (wbEnableB_i && wbAddrB_i == rd_addr[r]) rd_data[r] = wbDataB_i;
            else if (wbEnableA_i && wbAddrA_i == rd_addr[r]) rd_data[r] = wbDataA_i;
            else                                             rd_data[r] = rf_q[rd_addr[r]];
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
            for (int p = 0; p < 2; p++) begin
                occ_q[p] <= '0;
                en_q[p]  <= 1'b0;
                pw_q[p]  <= 1'b0;
                ft_q[p]  <= '0;
                op_q[p]  <= '0;
                dst_q[p] <= '0;
                pv_q[p]  <= '0;
                sv_q[p]  <= '0;
            end
            stalled_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            // Port B is written last so it wins a same-address collision.
            if (wbEnableA_i && wbAddrA_i != '0) rf_q[wbAddrA_i] <= wbDataA_i;
            if (wbEnableB_i && wbAddrB_i != '0) rf_q[wbAddrB_i] <= wbDataB_i;
            for (int p = 0; p < 2; p++) begin
                occ_q[p] <= occ_d[p];
                if (!shouldStall_i) begin
                    en_q[p]  <= sel_vld[p];
                    pw_q[p]  <= sel[p].pwrite;
                    ft_q[p]  <= sel[p].ftype;
                    op_q[p]  <= sel[p].opcode;
                    dst_q[p] <= sel[p].prim;
                    pv_q[p]  <= sel[p].pread ? rd_data[2*p] : '0;
                    sv_q[p]  <= sel[p].sread ? rd_data[2*p+1] : sel[p].sec;
                end
            end
            stalled_q <= stall_d;
            if (drop[0] || drop[1]) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        skid_q <= skid_d;
    end

    assign isStalled_o     = stalled_q;
    assign overflow_o      = ovf_q;
    assign enableA_o       = en_q[0];
    assign pwriteA_o       = pw_q[0];
    assign functionTypeA_o = ft_q[0];
    assign opcodeA_o       = op_q[0];
    assign destRegA_o      = dst_q[0];
    assign primValueA_o    = pv_q[0];
    assign secValueA_o     = sv_q[0];
    assign enableB_o       = en_q[1];
    assign pwriteB_o       = pw_q[1];
    assign functionTypeB_o = ft_q[1];
    assign opcodeB_o       = op_q[1];
    assign destRegB_o      = dst_q[1];
    assign primValueB_o    = pv_q[1];
    assign secValueB_o     = sv_q[1];
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: register file, bypass, stall skid,
// overflow and asynchronous reset behaviour.
module tb_operand_fetch;
    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        enableA_i, pWriteA_i, pReadA_i, sReadA_i;
    logic [1:0]  functionTypeA_i;
    logic [6:0]  opcodeA_i;
    logic [4:0]  primOperandA_i;
    logic [15:0] secOperandA_i;
    logic        enableB_i, pWriteB_i, pReadB_i, sReadB_i;
    logic [1:0]  functionTypeB_i;
    logic [6:0]  opcodeB_i;
    logic [4:0]  primOperandB_i;
    logic [15:0] secOperandB_i;
    logic        shouldStall_i;
    logic        wbEnableA_i, wbEnableB_i;
    logic [4:0]  wbAddrA_i, wbAddrB_i;
    logic [15:0] wbDataA_i, wbDataB_i;
    logic        isStalled_o, overflow_o;
    logic        enableA_o, pwriteA_o, enableB_o, pwriteB_o;
    logic [1:0]  functionTypeA_o, functionTypeB_o;
    logic [6:0]  opcodeA_o, opcodeB_o;
    logic [4:0]  destRegA_o, destRegB_o;
    logic [15:0] primValueA_o, secValueA_o, primValueB_o, secValueB_o;

    int errors = 0;
    int checks = 0;

    operand_fetch dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .enableA_i(enableA_i), .pWriteA_i(pWriteA_i), .pReadA_i(pReadA_i), .sReadA_i(sReadA_i),
        .functionTypeA_i(functionTypeA_i), .opcodeA_i(opcodeA_i),
        .primOperandA_i(primOperandA_i), .secOperandA_i(secOperandA_i),
        .enableB_i(enableB_i), .pWriteB_i(pWriteB_i), .pReadB_i(pReadB_i), .sReadB_i(sReadB_i),
        .functionTypeB_i(functionTypeB_i), .opcodeB_i(opcodeB_i),
        .primOperandB_i(primOperandB_i), .secOperandB_i(secOperandB_i),
        .shouldStall_i(shouldStall_i),
        .wbEnableA_i(wbEnableA_i), .wbAddrA_i(wbAddrA_i), .wbDataA_i(wbDataA_i),
        .wbEnableB_i(wbEnableB_i), .wbAddrB_i(wbAddrB_i), .wbDataB_i(wbDataB_i),
        .isStalled_o(isStalled_o),
        .enableA_o(enableA_o), .pwriteA_o(pwriteA_o), .functionTypeA_o(functionTypeA_o),
        .opcodeA_o(opcodeA_o), .destRegA_o(destRegA_o),
        .primValueA_o(primValueA_o), .secValueA_o(secValueA_o),
        .enableB_o(enableB_o), .pwriteB_o(pwriteB_o), .functionTypeB_o(functionTypeB_o),
        .opcodeB_o(opcodeB_o), .destRegB_o(destRegB_o),
        .primValueB_o(primValueB_o), .secValueB_o(secValueB_o),
        .overflow_o(overflow_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle();
        enableA_i = 0; pWriteA_i = 0; pReadA_i = 0; sReadA_i = 0;
        functionTypeA_i = 0; opcodeA_i = 0; primOperandA_i = 0; secOperandA_i = 0;
        enableB_i = 0; pWriteB_i = 0; pReadB_i = 0; sReadB_i = 0;
        functionTypeB_i = 0; opcodeB_i = 0; primOperandB_i = 0; secOperandB_i = 0;
        wbEnableA_i = 0; wbAddrA_i = 0; wbDataA_i = 0;
        wbEnableB_i = 0; wbAddrB_i = 0; wbDataB_i = 0;
    endtask

    task automatic sendA(input logic pr, input logic sr, input logic [6:0] op,
                         input logic [4:0] prim, input logic [15:0] sec);
        enableA_i = 1; pWriteA_i = 1; pReadA_i = pr; sReadA_i = sr;
        functionTypeA_i = 2'd2; opcodeA_i = op; primOperandA_i = prim; secOperandA_i = sec;
    endtask

    initial begin
        idle();
        shouldStall_i = 0;
        repeat (2) @(posedge clock_i);
        #1;
        chk("rst_enA", enableA_o, 0);
        chk("rst_stall", isStalled_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_primA", primValueA_o, 0);
        reset_i = 1;

        // Write R3, read it the following cycle
        wbEnableA_i = 1; wbAddrA_i = 3; wbDataA_i = 16'h1234;
        tick();
        idle();
        sendA(1, 0, 7'h05, 5'd3, 16'h00FF);
        tick();
        chk("r3_enA", enableA_o, 1);
        chk("r3_primA", primValueA_o, 16'h1234);
        chk("r3_secA", secValueA_o, 16'h00FF);
        chk("r3_dstA", destRegA_o, 3);
        chk("r3_opA", opcodeA_o, 7'h05);
        chk("r3_ftA", functionTypeA_o, 2);
        chk("r3_pwA", pwriteA_o, 1);
        idle();
        tick();
        chk("bubble_enA", enableA_o, 0);

        // Dual write to R5 with same-cycle bypassed read on pipe B
        wbEnableA_i = 1; wbAddrA_i = 5; wbDataA_i = 16'h1111;
        wbEnableB_i = 1; wbAddrB_i = 5; wbDataB_i = 16'h2222;
        enableB_i = 1; sReadB_i = 1; secOperandB_i = 16'h0005; primOperandB_i = 5'd9;
        tick();
        chk("byp_enB", enableB_o, 1);
        chk("byp_secB", secValueB_o, 16'h2222);
        chk("byp_primB", primValueB_o, 0);
        chk("byp_dstB", destRegB_o, 9);
        idle();
        sendA(1, 0, 7'h06, 5'd5, 16'h0000);
        tick();
        chk("r5_primA", primValueA_o, 16'h2222);

        // R0 stays zero, even with a same-cycle write
        idle();
        wbEnableA_i = 1; wbAddrA_i = 0; wbDataA_i = 16'hFFFF;
        sendA(1, 1, 7'h07, 5'd0, 16'h0000);
        tick();
        chk("r0_byp_prim", primValueA_o, 0);
        chk("r0_byp_sec", secValueA_o, 0);
        idle();
        sendA(1, 0, 7'h08, 5'd0, 16'h0000);
        tick();
        chk("r0_prim", primValueA_o, 0);

        // Stall with two instructions captured in the skid
        idle();
        sendA(0, 0, 7'h10, 5'd1, 16'h0001);
        tick();
        chk("i0_op", opcodeA_o, 7'h10);
        shouldStall_i = 1;
        sendA(1, 0, 7'h11, 5'd3, 16'h0000);
        tick();
        chk("st1_op", opcodeA_o, 7'h10);
        chk("st1_stall", isStalled_o, 1);
        sendA(0, 0, 7'h12, 5'd4, 16'h0AAA);
        tick();
        chk("st2_op", opcodeA_o, 7'h10);
        chk("st2_stall", isStalled_o, 1);
        idle();
        wbEnableA_i = 1; wbAddrA_i = 3; wbDataA_i = 16'h4321;
        tick();
        chk("st3_op", opcodeA_o, 7'h10);
        chk("st3_stall", isStalled_o, 1);
        chk("st3_ovf", overflow_o, 0);
        idle();
        shouldStall_i = 0;
        tick();
        chk("dr1_op", opcodeA_o, 7'h11);
        chk("dr1_prim", primValueA_o, 16'h4321);
        chk("dr1_stall", isStalled_o, 1);
        tick();
        chk("dr2_op", opcodeA_o, 7'h12);
        chk("dr2_sec", secValueA_o, 16'h0AAA);
        chk("dr2_en", enableA_o, 1);
        chk("dr2_stall", isStalled_o, 0);
        tick();
        chk("dr3_en", enableA_o, 0);

        // Third instruction into a full skid is dropped
        shouldStall_i = 1;
        sendA(0, 0, 7'h21, 5'd1, 16'h0000);
        tick();
        sendA(0, 0, 7'h22, 5'd2, 16'h0000);
        tick();
        sendA(0, 0, 7'h23, 5'd3, 16'h0000);
        tick();
        chk("ov_flag", overflow_o, 1);
        chk("ov_frozen_en", enableA_o, 0);
        idle();
        tick();
        chk("ov_sticky1", overflow_o, 1);
        shouldStall_i = 0;
        tick();
        chk("ov_d1_op", opcodeA_o, 7'h21);
        tick();
        chk("ov_d2_op", opcodeA_o, 7'h22);
        chk("ov_d2_en", enableA_o, 1);
        tick();
        chk("ov_no3_en", enableA_o, 0);
        chk("ov_sticky2", overflow_o, 1);

        // Asynchronous reset with two skid entries pending
        sendA(1, 0, 7'h30, 5'd3, 16'h0000);
        tick();
        chk("pre_rst_op", opcodeA_o, 7'h30);
        shouldStall_i = 1;
        sendA(0, 0, 7'h31, 5'd1, 16'h0000);
        tick();
        sendA(0, 0, 7'h32, 5'd2, 16'h0000);
        tick();
        chk("pre_rst_stall", isStalled_o, 1);
        #2;
        reset_i = 0;
        #1;
        chk("ar_enA", enableA_o, 0);
        chk("ar_opA", opcodeA_o, 0);
        chk("ar_primA", primValueA_o, 0);
        chk("ar_stall", isStalled_o, 0);
        chk("ar_ovf", overflow_o, 0);
        idle();
        shouldStall_i = 0;
        @(negedge clock_i);
        reset_i = 1;
        sendA(1, 0, 7'h40, 5'd3, 16'h0000);
        tick();
        chk("post_rst_en", enableA_o, 1);
        chk("post_rst_op", opcodeA_o, 7'h40);
        chk("post_rst_r3", primValueA_o, 0);
        idle();
        tick();
        chk("post_rst_drain", enableA_o, 0);
        chk("post_rst_stall", isStalled_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
